// File: rtl/pe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_pkg : shared lane geometry, vector type and FSM states for PE   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pe_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 64;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pe_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_accum_if : vector stream in, frame result out, with backpressure|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface pe_accum_if;
  import pe_pkg::*;

  vec_t             D;
  logic             D_VALID;
  logic             D_BP;
  vec_t             Q;
  logic [LANES-1:0] Q_CARRY;
  logic             Q_VALID;
  logic             Q_BP;
  logic             ERR_OVF;

  modport slave (
    input  D, D_VALID, Q_BP,
    output D_BP, Q, Q_CARRY, Q_VALID, ERR_OVF
  );

  modport master (
    output D, D_VALID, Q_BP,
    input  D_BP, Q, Q_CARRY, Q_VALID, ERR_OVF
  );

endinterface
`default_nettype wire

// File: rtl/pe_fifo_fwft.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_fifo_fwft : register-based first-word-fall-through FIFO         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pe_fifo_fwft #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  wire logic                   CLK,
  input  wire logic                   RST,
  input  wire logic                   wr_en,
  input  T                            din,
  input  wire logic                   rd_en,
  output T                            dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int                AW     = $clog2(DEPTH);
  localparam logic [AW:0]       C_FULL = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign w_pop  = rd_en && (r_count != '0);
  assign w_push = wr_en && ((r_count != C_FULL) || w_pop);

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == C_FULL);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pe_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_accum : lane-wise frame accumulator with sticky per-lane carry  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pe_accum
  import pe_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 4,
  parameter int LEN_W = 16
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic [LEN_W-1:0] CFG_LEN,
  pe_accum_if.slave             bus
);

  localparam int             CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  C_BP_LEVEL = CW'(DEPTH - SLACK);
  localparam logic [LEN_W-1:0] C_ONE    = LEN_W'(1);

  vec_t             w_head;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic             w_pop;
  logic             w_push_ok;
  logic [CW-1:0]    w_count_nxt;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_cnt_inc;
  vec_t             w_sum;
  logic [LANES-1:0] w_cout;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  vec_t             r_acc;
  logic [LANES-1:0] r_carry;
  vec_t             r_q;
  logic [LANES-1:0] r_q_carry;
  logic             r_q_valid;
  logic             r_d_bp;
  logic             r_err_ovf;

  pe_fifo_fwft #(
    .DEPTH (DEPTH),
    .T     (vec_t)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .wr_en (bus.D_VALID),
    .din   (bus.D),
    .rd_en (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign w_pop       = ((r_state == IDLE) || (r_state == ACC)) && !w_empty;
  assign w_push_ok   = bus.D_VALID && (!w_full || w_pop);
  assign w_count_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);
  assign w_len       = (CFG_LEN == '0) ? C_ONE : CFG_LEN;
  assign w_cnt_inc   = r_cnt + C_ONE;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign {w_cout[i], w_sum[i]} = {1'b0, r_acc[i]} + {1'b0, w_head[i]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_len     <= C_ONE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_carry   <= '0;
      r_q       <= '0;
      r_q_carry <= '0;
      r_q_valid <= 1'b0;
      r_d_bp    <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      r_d_bp    <= (w_count_nxt >= C_BP_LEVEL);
      if (bus.D_VALID && w_full && !w_pop) begin
        r_err_ovf <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_len   <= w_len;
            r_acc   <= w_head;
            r_carry <= '0;
            r_cnt   <= C_ONE;
            r_state <= (w_len == C_ONE) ? OUT : ACC;
          end
        end
        ACC: begin
          if (!w_empty) begin
            r_acc   <= w_sum;
            r_carry <= r_carry | w_cout;
            r_cnt   <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_state <= OUT;
            end
          end
        end
        OUT: begin
          // Downstream stall holds the finished frame; input keeps filling the FIFO.
          if (!bus.Q_BP) begin
            r_q       <= r_acc;
            r_q_carry <= r_carry;
            r_q_valid <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Q       = r_q;
  assign bus.Q_CARRY = r_q_carry;
  assign bus.Q_VALID = r_q_valid;
  assign bus.D_BP    = r_d_bp;
  assign bus.ERR_OVF = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pe_accum : directed + randomized bench with frame-sum reference |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pe_accum;
  import pe_pkg::*;

  localparam int DEPTH = 16;
  localparam int SLACK = 4;
  localparam int LEN_W = 16;

  typedef struct {
    vec_t             q;
    logic [LANES-1:0] c;
  } res_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [LEN_W-1:0] CFG_LEN;

  pe_accum_if bus();

  pe_accum #(
    .DEPTH (DEPTH),
    .SLACK (SLACK),
    .LEN_W (LEN_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CFG_LEN (CFG_LEN),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mlen  = 1;
  res_t exp_q [$];
  vec_t pend  [$];
  int   pulse_cyc [$];
  res_t mon_r;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a frame's lane result is the plain integer total of its beats;
  // the low 64 bits are Q and any excess above 2^64 means a carry occurred.
  task automatic model_beat(input vec_t d);
    res_t       r;
    logic [79:0] tot;
    pend.push_back(d);
    if (pend.size() == mlen) begin
      for (int l = 0; l < LANES; l++) begin
        tot = '0;
        foreach (pend[b]) tot += 80'(pend[b][l]);
        r.q[l] = tot[63:0];
        r.c[l] = (tot[79:64] != '0);
      end
      exp_q.push_back(r);
      pend.delete();
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l] = {$urandom, $urandom};
    return v;
  endfunction

  function automatic vec_t fill_vec(input logic [63:0] x);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l] = x;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input vec_t d);
    bus.D       = d;
    bus.D_VALID = 1'b1;
    tick();
    bus.D_VALID = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.Q_BP    = 1'b0;
    bus.D_VALID = 1'b0;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_q"},       bus.Q,       '0);
    chk({tag, "_carry"},   bus.Q_CARRY, '0);
    chk({tag, "_qvalid"},  bus.Q_VALID, 1'b0);
    chk({tag, "_dbp"},     bus.D_BP,    1'b0);
    chk({tag, "_errovf"},  bus.ERR_OVF, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (!RST && bus.Q_VALID) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_qvalid", bus.Q_VALID, 1'b0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("result_q",     bus.Q,       mon_r.q);
        chk("result_carry", bus.Q_CARRY, mon_r.c);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d expected to finish earlier", cyc);
    $fatal(1);
  end

  initial begin
    vec_t d;
    int   t0;
    int   len;
    int   nb;

    bus.D       = '0;
    bus.D_VALID = 1'b0;
    bus.Q_BP    = 1'b0;
    CFG_LEN     = LEN_W'(1);
    RST         = 1'b1;
    tick();
    tick();
    chk_zero_outputs("reset");
    RST = 1'b0;
    tick();

    // Single beat, len 1: pulse two edges after the push edge
    mlen = 1;
    CFG_LEN = LEN_W'(1);
    for (int l = 0; l < LANES; l++) d[l] = 64'(l + 1);
    model_beat(d);
    pulse_cyc.delete();
    bus.D = d;
    bus.D_VALID = 1'b1;
    tick();
    t0 = cyc;
    bus.D_VALID = 1'b0;
    drain(20);
    chk("single_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0) chk("single_latency", pulse_cyc[0], t0 + 2);

    // Two back-to-back frames of length 4
    mlen = 4;
    CFG_LEN = LEN_W'(4);
    pulse_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      d = fill_vec(64'((k % 4) + 1));
      model_beat(d);
      push(d);
    end
    drain(40);
    chk("len4_npulse", pulse_cyc.size(), 2);
    if (pulse_cyc.size() > 1) chk("len4_spacing", pulse_cyc[1] - pulse_cyc[0], 5);
    chk("len4_lane7", bus.Q[7], 64'd10);

    // Lane 0 wraps; others stay small
    mlen = 2;
    CFG_LEN = LEN_W'(2);
    for (int l = 0; l < LANES; l++) d[l] = 64'(l);
    d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    model_beat(d);
    push(d);
    for (int l = 0; l < LANES; l++) d[l] = 64'(10 * l);
    d[0] = 64'd2;
    model_beat(d);
    push(d);
    drain(20);
    repeat (3) tick();
    chk("wrap_hold_lane0", bus.Q[0], 64'd1);
    chk("wrap_hold_carry", bus.Q_CARRY, 8'h01);
    chk("wrap_hold_lane3", bus.Q[3], 64'd33);

    // Backpressure: D_BP must rise exactly when occupancy reaches DEPTH-SLACK
    mlen = 1;
    CFG_LEN = LEN_W'(1);
    bus.Q_BP = 1'b1;
    for (int k = 0; k < 20 && !bus.D_BP; k++) begin
      d = rand_vec();
      model_beat(d);
      push(d);
      chk("dbp_level", bus.D_BP, (k >= DEPTH - SLACK));
    end
    for (int k = 0; k < SLACK; k++) begin
      d = rand_vec();
      model_beat(d);
      push(d);
    end
    chk("bp_no_ovf", bus.ERR_OVF, 1'b0);
    drain(200);
    chk("bp_dbp_released", bus.D_BP, 1'b0);

    // Overflow: one beat sits in the accumulator, DEPTH in the FIFO, rest dropped
    bus.Q_BP = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = rand_vec();
      if (k <= DEPTH) model_beat(d);
      push(d);
      chk("ovf_flag", bus.ERR_OVF, (k > DEPTH));
    end
    drain(200);
    chk("ovf_sticky", bus.ERR_OVF, 1'b1);

    // Reset in the middle of a length-8 frame
    mlen = 8;
    CFG_LEN = LEN_W'(8);
    for (int k = 0; k < 3; k++) push(rand_vec());
    RST = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    tick();
    RST = 1'b0;
    pend.delete();
    exp_q.delete();
    tick();
    for (int k = 0; k < 8; k++) begin
      d = fill_vec(64'd1);
      model_beat(d);
      push(d);
    end
    drain(40);
    chk("after_reset_lane5", bus.Q[5], 64'd8);

    // Randomized phases, producer honours D_BP, random downstream stalls
    for (int ph = 0; ph < 8; ph++) begin
      len = $urandom_range(0, 5);
      CFG_LEN = LEN_W'(len);
      mlen = (len == 0) ? 1 : len;
      nb = mlen * $urandom_range(2, 4);
      for (int g = 0; g < 2000 && nb > 0; g++) begin
        bus.Q_BP = ($urandom_range(0, 3) == 0);
        if (!bus.D_BP && $urandom_range(0, 2) != 0) begin
          d = rand_vec();
          if ($urandom_range(0, 3) == 0) d[$urandom_range(0, LANES - 1)] = 64'hFFFF_FFFF_FFFF_FFFF;
          model_beat(d);
          bus.D = d;
          bus.D_VALID = 1'b1;
          nb--;
        end else begin
          bus.D_VALID = 1'b0;
        end
        tick();
      end
      bus.D_VALID = 1'b0;
      drain(400);
    end
    chk("random_no_ovf", bus.ERR_OVF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
